// File: rtl/network_request_injector.sv
// network_request_injector: buffers host read/write requests and serialises
// them as single-cycle flits onto a mesh Node input port; one read in flight.
//
// Ports:
//   clk, reset (async, active-low)
//   localRouterAddress   : requester id stamped on every flit
//   reqValid/reqReady    : host request handshake (reqReady = !full)
//   reqWrite/reqAddress/reqData : request payload
//   respValid/respData/respError : read completion pulse (error = timeout)
//   busy                 : FIFO non-empty or FSM not idle
//   *Out                 : flit towards the Node input port
//   *In                  : reply flit from the Node output port
module network_request_injector #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int NETWORK_ADDRESS_WIDTH = 4,
  parameter int CACHE_BANK_ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic [NETWORK_ADDRESS_WIDTH-1:0] localRouterAddress,
  input  logic reqValid,
  output logic reqReady,
  input  logic reqWrite,
  input  logic [NETWORK_ADDRESS_WIDTH+CACHE_BANK_ADDRESS_WIDTH-1:0] reqAddress,
  input  logic [DATA_WIDTH-1:0] reqData,
  output logic respValid,
  output logic [DATA_WIDTH-1:0] respData,
  output logic respError,
  output logic busy,
  output logic [NETWORK_ADDRESS_WIDTH+CACHE_BANK_ADDRESS_WIDTH-1:0] destinationAddressOut,
  output logic [NETWORK_ADDRESS_WIDTH-1:0] requesterAddressOut,
  output logic readOut,
  output logic writeOut,
  output logic [DATA_WIDTH-1:0] dataOut,
  input  logic [NETWORK_ADDRESS_WIDTH+CACHE_BANK_ADDRESS_WIDTH-1:0] destinationAddressIn,
  input  logic [NETWORK_ADDRESS_WIDTH-1:0] requesterAddressIn,
  input  logic readIn,
  input  logic writeIn,
  input  logic [DATA_WIDTH-1:0] dataIn
);

  localparam int NAW = NETWORK_ADDRESS_WIDTH;
  localparam int GAW = NETWORK_ADDRESS_WIDTH + CACHE_BANK_ADDRESS_WIDTH;
  localparam int DW  = DATA_WIDTH;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES);

  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic           isWrite;
    logic [GAW-1:0] address;
    logic [DW-1:0]  data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP
  } state_t;

  entry_t fifoMem [FIFO_DEPTH];
  entry_t head;
  entry_t newEntry;

  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] count;
  logic [CW-1:0] countNext;
  logic push;
  logic pop;

  state_t state;
  state_t stateNext;
  logic [TW-1:0] timer;
  logic [TW-1:0] timerNext;

  logic replyHit;
  logic timeoutHit;

  logic [GAW-1:0] destNext;
  logic [NAW-1:0] reqAddrNext;
  logic readNext;
  logic writeNext;
  logic [DW-1:0] dataNext;
  logic respValidNext;
  logic [DW-1:0] respDataNext;
  logic respErrorNext;

  // Reply destination is not needed to match a read to this requester.
  logic unusedSinks;
  assign unusedSinks = ^destinationAddressIn;

  assign push = reqValid && reqReady;
  assign head = fifoMem[rdPtr];

  assign newEntry.isWrite = reqWrite;
  assign newEntry.address = reqAddress;
  assign newEntry.data    = reqData;

  assign replyHit = readIn && !writeIn &&
                    (requesterAddressIn == localRouterAddress);
  assign timeoutHit = (timer == LAST);

  assign countNext = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr] <= newEntry;
    end
  end

  always_comb begin
    stateNext     = state;
    timerNext     = timer;
    pop           = 1'b0;
    destNext      = '0;
    reqAddrNext   = '0;
    readNext      = 1'b0;
    writeNext     = 1'b0;
    dataNext      = '0;
    respValidNext = 1'b0;
    respDataNext  = '0;
    respErrorNext = 1'b0;
    unique case (state)
      IDLE: begin
        // Hold off one cycle after a completion so the
        // requester sees its response before the next flit.
        if ((count != '0) && !respValid) begin
          stateNext   = ISSUE;
          destNext    = head.address;
          reqAddrNext = localRouterAddress;
          readNext    = !head.isWrite;
          writeNext   = head.isWrite;
          dataNext    = head.isWrite ? head.data : '0;
        end
      end
      ISSUE: begin
        pop = 1'b1;
        timerNext = '0;
        if (head.isWrite) begin
          stateNext = IDLE;
        end else begin
          stateNext = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        timerNext = timer + TW'(1);
        // A reply in the terminal cycle beats the timeout.
        if (replyHit) begin
          stateNext     = IDLE;
          timerNext     = '0;
          respValidNext = 1'b1;
          respDataNext  = dataIn;
        end else if (timeoutHit) begin
          stateNext     = IDLE;
          timerNext     = '0;
          respValidNext = 1'b1;
          respErrorNext = 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        timerNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                 <= IDLE;
      timer                 <= '0;
      wrPtr                 <= '0;
      rdPtr                 <= '0;
      count                 <= '0;
      reqReady              <= 1'b1;
      busy                  <= 1'b0;
      respValid             <= 1'b0;
      respData              <= '0;
      respError             <= 1'b0;
      destinationAddressOut <= '0;
      requesterAddressOut   <= '0;
      readOut               <= 1'b0;
      writeOut              <= 1'b0;
      dataOut               <= '0;
    end else begin
      state <= stateNext;
      timer <= timerNext;
      if (push) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      count                 <= countNext;
      reqReady              <= (countNext != FULL);
      busy                  <= (countNext != '0) || (stateNext != IDLE);
      respValid             <= respValidNext;
      respData              <= respDataNext;
      respError             <= respErrorNext;
      destinationAddressOut <= destNext;
      requesterAddressOut   <= reqAddrNext;
      readOut               <= readNext;
      writeOut              <= writeNext;
      dataOut               <= dataNext;
    end
  end

endmodule

// File: tb/tb_network_request_injector.sv
// tb_network_request_injector: directed and randomized checks of the
// request injector against a transaction-level model.
module tb_network_request_injector;

  localparam int T = 64;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] localRouterAddress;
  logic reqValid;
  logic reqReady;
  logic reqWrite;
  logic [11:0] reqAddress;
  logic [7:0] reqData;
  logic respValid;
  logic [7:0] respData;
  logic respError;
  logic busy;
  logic [11:0] destinationAddressOut;
  logic [3:0] requesterAddressOut;
  logic readOut;
  logic writeOut;
  logic [7:0] dataOut;
  logic [11:0] destinationAddressIn;
  logic [3:0] requesterAddressIn;
  logic readIn;
  logic writeIn;
  logic [7:0] dataIn;

  int passCnt = 0;
  int totalCnt = 0;
  int cyc = 0;

  typedef struct {
    int c;
    logic wr;
    logic rd;
    logic [11:0] a;
    logic [3:0] r;
    logic [7:0] d;
  } flit_t;

  typedef struct {
    int c;
    logic e;
    logic [7:0] d;
  } resp_t;

  flit_t flits[$];
  resp_t resps[$];
  flit_t mf;
  resp_t mr;

  bit autoReply = 1'b0;
  int replyAt = -1;
  logic [7:0] replyData;
  resp_t expResp[$];
  int rd;
  resp_t er;

  network_request_injector dut (
    .clk(clk),
    .reset(reset),
    .localRouterAddress(localRouterAddress),
    .reqValid(reqValid),
    .reqReady(reqReady),
    .reqWrite(reqWrite),
    .reqAddress(reqAddress),
    .reqData(reqData),
    .respValid(respValid),
    .respData(respData),
    .respError(respError),
    .busy(busy),
    .destinationAddressOut(destinationAddressOut),
    .requesterAddressOut(requesterAddressOut),
    .readOut(readOut),
    .writeOut(writeOut),
    .dataOut(dataOut),
    .destinationAddressIn(destinationAddressIn),
    .requesterAddressIn(requesterAddressIn),
    .readIn(readIn),
    .writeIn(writeIn),
    .dataIn(dataIn)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Record every flit and completion with the cycle it was seen in.
  always @(negedge clk) begin
    if (readOut || writeOut) begin
      mf.c = cyc;
      mf.wr = writeOut;
      mf.rd = readOut;
      mf.a = destinationAddressOut;
      mf.r = requesterAddressOut;
      mf.d = dataOut;
      flits.push_back(mf);
    end
    if (respValid) begin
      mr.c = cyc;
      mr.e = respError;
      mr.d = respData;
      resps.push_back(mr);
    end
    // Random remote node: answer a read after d cycles or never.
    if (autoReply && readOut) begin
      rd = $urandom_range(1, T + 8);
      if ($urandom_range(0, 3) == 0) rd = T;
      if (rd <= T) begin
        replyAt = cyc + rd;
        replyData = 8'($urandom);
        er.c = cyc + rd + 1;
        er.e = 1'b0;
        er.d = replyData;
      end else begin
        replyAt = -1;
        er.c = cyc + T + 1;
        er.e = 1'b1;
        er.d = 8'h00;
      end
      expResp.push_back(er);
    end
  end

  always @(posedge clk) begin
    if (autoReply) begin
      #1;
      if (cyc == replyAt) begin
        readIn = 1'b1;
        writeIn = 1'b0;
        requesterAddressIn = localRouterAddress;
        dataIn = replyData;
        destinationAddressIn = 12'($urandom);
      end else begin
        readIn = 1'b0;
        dataIn = 8'h00;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic clear_reply();
    readIn = 1'b0;
    writeIn = 1'b0;
    requesterAddressIn = 4'h0;
    dataIn = 8'h00;
    destinationAddressIn = 12'h000;
  endtask

  task automatic send_reply(input logic [3:0] who, input logic [7:0] d);
    readIn = 1'b1;
    writeIn = 1'b0;
    requesterAddressIn = who;
    dataIn = d;
    destinationAddressIn = 12'h600;
    tick();
    clear_reply();
  endtask

  task automatic push(input bit w, input logic [11:0] a,
                      input logic [7:0] d, output int acc);
    bit ok = 1'b0;
    acc = -1;
    reqValid = 1'b1;
    reqWrite = w;
    reqAddress = a;
    reqData = d;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (reqReady) begin
        acc = cyc;
        ok = 1'b1;
      end
      tick();
    end
    reqValid = 1'b0;
    reqWrite = 1'b0;
    reqAddress = 12'h000;
    reqData = 8'h00;
    if (!ok) begin
      totalCnt++;
      $display("FAIL push_stall reqReady=%b required=1", reqReady);
    end
  endtask

  task automatic wait_idle(input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    totalCnt++;
    if (i == bound) $display("FAIL idle_bound busy=%b required=0", busy);
    else passCnt++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    @(negedge clk);
    totalCnt++;
    if (reqReady !== 1'b1) $display("FAIL rst_ready got=%b exp=1", reqReady);
    else passCnt++;
    totalCnt++;
    if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy);
    else passCnt++;
    totalCnt++;
    if ({respValid, respError, respData} !== 10'h0)
      $display("FAIL rst_resp got=%h exp=0", {respValid, respError, respData});
    else passCnt++;
    totalCnt++;
    if ({destinationAddressOut, requesterAddressOut, readOut, writeOut, dataOut} !== 26'h0)
      $display("FAIL rst_flit got=%h exp=0",
               {destinationAddressOut, requesterAddressOut, readOut, writeOut, dataOut});
    else passCnt++;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_write();
    int n;
    flit_t f;
    tick();
    flits.delete();
    resps.delete();
    push(1'b1, 12'h005, 8'hA5, n);
    @(negedge clk);
    totalCnt++;
    if (busy !== 1'b1) $display("FAIL wr_busy got=%b exp=1", busy);
    else passCnt++;
    wait_cyc(n + 6);
    totalCnt++;
    if (flits.size() !== 1) $display("FAIL wr_nflits got=%0d exp=1", flits.size());
    else passCnt++;
    if (flits.size() >= 1) begin
      f = flits[0];
      totalCnt++;
      if (f.c !== n + 2) $display("FAIL wr_cycle got=%0d exp=%0d", f.c, n + 2);
      else passCnt++;
      totalCnt++;
      if ({f.wr, f.rd, f.a, f.r, f.d} !== {2'b10, 12'h005, localRouterAddress, 8'hA5})
        $display("FAIL wr_flit got=%h exp=%h", {f.wr, f.rd, f.a, f.r, f.d},
                 {2'b10, 12'h005, localRouterAddress, 8'hA5});
      else passCnt++;
    end
    totalCnt++;
    if (resps.size() !== 0) $display("FAIL wr_noresp got=%0d exp=0", resps.size());
    else passCnt++;
  endtask

  task automatic test_read_reply();
    int n, f;
    tick();
    flits.delete();
    resps.delete();
    push(1'b0, 12'h103, 8'hFF, n);
    f = n + 2;
    wait_cyc(f + 10);
    send_reply(localRouterAddress, 8'h3C);
    wait_cyc(f + 16);
    totalCnt++;
    if (flits.size() !== 1 || flits[0].c !== f || flits[0].rd !== 1'b1 ||
        flits[0].wr !== 1'b0 || flits[0].a !== 12'h103 || flits[0].d !== 8'h00)
      $display("FAIL rd_flit nflits=%0d exp=1 at=%0d", flits.size(), f);
    else passCnt++;
    totalCnt++;
    if (resps.size() !== 1) $display("FAIL rd_nresp got=%0d exp=1", resps.size());
    else passCnt++;
    if (resps.size() >= 1) begin
      totalCnt++;
      if ({resps[0].c, resps[0].e, resps[0].d} !== {f + 11, 1'b0, 8'h3C})
        $display("FAIL rd_resp got=%0d/%b/%h exp=%0d/0/3c",
                 resps[0].c, resps[0].e, resps[0].d, f + 11);
      else passCnt++;
    end
  endtask

  task automatic test_timeout(input bit wrongReq);
    int n, f;
    tick();
    flits.delete();
    resps.delete();
    push(1'b0, wrongReq ? 12'h03A : 12'h210, 8'h00, n);
    f = n + 2;
    if (wrongReq) begin
      wait_cyc(f + 5);
      send_reply(localRouterAddress ^ 4'h1, 8'h77);
    end
    wait_cyc(f + T + 5);
    send_reply(localRouterAddress, 8'h99);
    wait_cyc(f + T + 12);
    totalCnt++;
    if (resps.size() !== 1) $display("FAIL to_nresp wrong=%b got=%0d exp=1", wrongReq, resps.size());
    else passCnt++;
    if (resps.size() >= 1) begin
      totalCnt++;
      if ({resps[0].c, resps[0].e, resps[0].d} !== {f + T + 1, 1'b1, 8'h00})
        $display("FAIL to_resp wrong=%b got=%0d/%b/%h exp=%0d/1/00", wrongReq,
                 resps[0].c, resps[0].e, resps[0].d, f + T + 1);
      else passCnt++;
    end
  endtask

  task automatic test_fill();
    int n, f, acc5;
    flit_t exp[$];
    flit_t e;
    logic [11:0] a;
    logic [7:0] d;
    tick();
    flits.delete();
    resps.delete();
    a = 12'($urandom);
    push(1'b0, a, 8'h00, n);
    f = n + 2;
    e.wr = 1'b0; e.rd = 1'b1; e.a = a; e.r = localRouterAddress; e.d = 8'h00;
    exp.push_back(e);
    wait_cyc(f + 2);
    for (int k = 0; k < 5; k++) begin
      a = 12'($urandom);
      d = 8'($urandom);
      if (k == 4) begin
        @(negedge clk);
        totalCnt++;
        if (reqReady !== 1'b0) $display("FAIL fill_ready got=%b exp=0", reqReady);
        else passCnt++;
        tick();
      end
      push(1'b1, a, d, acc5);
      e.wr = 1'b1; e.rd = 1'b0; e.a = a; e.d = d;
      exp.push_back(e);
    end
    wait_idle(400);
    tick();
    tick();
    totalCnt++;
    if (flits.size() !== 6) $display("FAIL fill_nflits got=%0d exp=6", flits.size());
    else passCnt++;
    for (int i = 0; i < 6 && i < flits.size(); i++) begin
      totalCnt++;
      if ({flits[i].wr, flits[i].rd, flits[i].a, flits[i].r, flits[i].d} !==
          {exp[i].wr, exp[i].rd, exp[i].a, exp[i].r, exp[i].d})
        $display("FAIL fill_order idx=%0d got=%h/%h exp=%h/%h", i,
                 flits[i].a, flits[i].d, exp[i].a, exp[i].d);
      else passCnt++;
    end
    if (flits.size() == 6) begin
      totalCnt++;
      if (flits[1].c < f + T + 3)
        $display("FAIL fill_gap got=%0d exp>=%0d", flits[1].c, f + T + 3);
      else passCnt++;
      totalCnt++;
      if (acc5 !== flits[1].c + 1)
        $display("FAIL fill_holdoff got=%0d exp=%0d", acc5, flits[1].c + 1);
      else passCnt++;
      for (int i = 1; i < 5; i++) begin
        totalCnt++;
        if (flits[i + 1].c - flits[i].c !== 2)
          $display("FAIL b2b_spacing idx=%0d got=%0d exp=2", i, flits[i + 1].c - flits[i].c);
        else passCnt++;
      end
    end
    totalCnt++;
    if (resps.size() !== 1 || resps[0].e !== 1'b1 || resps[0].c !== f + T + 1)
      $display("FAIL fill_timeout nresp=%0d exp=1 at=%0d", resps.size(), f + T + 1);
    else passCnt++;
  endtask

  task automatic test_reset_wait();
    int n, f, x;
    tick();
    push(1'b0, 12'h344, 8'h00, n);
    f = n + 2;
    wait_cyc(f + 3);
    push(1'b1, 12'h011, 8'h12, x);
    push(1'b1, 12'h022, 8'h34, x);
    wait_cyc(f + 10);
    reset = 1'b0;
    @(negedge clk);
    totalCnt++;
    if ({reqReady, busy, respValid, respError, respData} !== 12'h800)
      $display("FAIL rstw_ctl got=%h exp=800", {reqReady, busy, respValid, respError, respData});
    else passCnt++;
    totalCnt++;
    if ({destinationAddressOut, requesterAddressOut, readOut, writeOut, dataOut} !== 26'h0)
      $display("FAIL rstw_flit got=%h exp=0",
               {destinationAddressOut, requesterAddressOut, readOut, writeOut, dataOut});
    else passCnt++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    flits.delete();
    resps.delete();
    wait_cyc(cyc + 25);
    @(negedge clk);
    totalCnt++;
    if (flits.size() !== 0 || resps.size() !== 0)
      $display("FAIL rstw_quiet flits=%0d resps=%0d exp=0/0", flits.size(), resps.size());
    else passCnt++;
    totalCnt++;
    if (busy !== 1'b0) $display("FAIL rstw_busy got=%b exp=0", busy);
    else passCnt++;
  endtask

  task automatic test_random();
    flit_t exp[$];
    flit_t e;
    bit w;
    logic [11:0] a;
    logic [7:0] d;
    int acc;
    tick();
    flits.delete();
    resps.delete();
    expResp.delete();
    autoReply = 1'b1;
    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      w = 1'($urandom_range(0, 1));
      a = 12'($urandom);
      d = 8'($urandom);
      push(w, a, d, acc);
      e.wr = w; e.rd = !w; e.a = a; e.r = localRouterAddress;
      e.d = w ? d : 8'h00;
      exp.push_back(e);
    end
    wait_idle(2000);
    tick();
    tick();
    tick();
    autoReply = 1'b0;
    tick();
    clear_reply();
    totalCnt++;
    if (flits.size() !== exp.size())
      $display("FAIL rnd_nflits got=%0d exp=%0d", flits.size(), exp.size());
    else passCnt++;
    for (int i = 0; i < exp.size() && i < flits.size(); i++) begin
      totalCnt++;
      if ({flits[i].wr, flits[i].rd, flits[i].a, flits[i].r, flits[i].d} !==
          {exp[i].wr, exp[i].rd, exp[i].a, exp[i].r, exp[i].d})
        $display("FAIL rnd_flit idx=%0d got=%b%b/%h/%h exp=%b%b/%h/%h", i,
                 flits[i].wr, flits[i].rd, flits[i].a, flits[i].d,
                 exp[i].wr, exp[i].rd, exp[i].a, exp[i].d);
      else passCnt++;
    end
    totalCnt++;
    if (resps.size() !== expResp.size())
      $display("FAIL rnd_nresp got=%0d exp=%0d", resps.size(), expResp.size());
    else passCnt++;
    for (int i = 0; i < expResp.size() && i < resps.size(); i++) begin
      totalCnt++;
      if ({resps[i].c, resps[i].e, resps[i].d} !== {expResp[i].c, expResp[i].e, expResp[i].d})
        $display("FAIL rnd_resp idx=%0d got=%0d/%b/%h exp=%0d/%b/%h", i,
                 resps[i].c, resps[i].e, resps[i].d,
                 expResp[i].c, expResp[i].e, expResp[i].d);
      else passCnt++;
    end
  endtask

  initial begin
    reset = 1'b0;
    localRouterAddress = 4'h6;
    reqValid = 1'b0;
    reqWrite = 1'b0;
    reqAddress = 12'h000;
    reqData = 8'h00;
    clear_reply();
    test_reset();
    test_write();
    test_read_reply();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_fill();
    test_reset_wait();
    test_random();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/network_request_injector.md
# network_request_injector

Host-side traffic source that sits directly upstream of a mesh `Node`: it accepts read/write requests from a local requester, buffers them, and serialises them as single-cycle flits onto one `Node` input port. It then consumes the read reply that comes back on the matching `Node` output port. It enforces one outstanding read at a time and supervises each read with a timeout, so a lost reply cannot hang the requester.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: request buffer entries; power of two, at least 2.
- `TIMEOUT_CYCLES`, 64: cycles spent in WAIT_RESP before a read is abandoned; at least 2.

Widths `NAW` = `NETWORK_ADDRESS_WIDTH`, `CAW` = `CACHE_BANK_ADDRESS_WIDTH` and `DW` = `DATA_WIDTH` come from `globalVariables.v`.

Ports:
- `clk`  in  1  sole clock; rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `localRouterAddress`  in  NAW  address of this requester; driven on every flit as requester address.
- `reqValid`  in  1  host request strobe.
- `reqReady`  out  1  buffer can accept; equals !full.
- `reqWrite`  in  1  1 = write, 0 = read.
- `reqAddress`  in  NAW+CAW  global address {node, bank word}.
- `reqData`  in  DW  write data; ignored for reads.
- `respValid`  out  1  one-cycle read-completion pulse.
- `respData`  out  DW  read data; 0 on error.
- `respError`  out  1  qualifies `respValid`: read timed out.
- `busy`  out  1  FIFO non-empty or state ≠ IDLE.
- `destinationAddressOut`  out  NAW+CAW  flit to the `Node` input port.
- `requesterAddressOut`  out  NAW  flit to the `Node` input port.
- `readOut`  out  1  flit to the `Node` input port.
- `writeOut`  out  1  flit to the `Node` input port.
- `dataOut`  out  DW  flit to the `Node` input port.
- `destinationAddressIn`  in  NAW+CAW  reply flit from the `Node` output port.
- `requesterAddressIn`  in  NAW  reply flit from the `Node` output port.
- `readIn`  in  1  reply flit from the `Node` output port.
- `writeIn`  in  1  reply flit from the `Node` output port.
- `dataIn`  in  DW  reply flit from the `Node` output port.

## Operation
- FIFO entry = {write, address, data}.
  - A push occurs when `reqValid && reqReady`.
  - A push while full is impossible, because `reqReady` is low.
  - Pointers are log2(FIFO_DEPTH) bits wide with a separate count; wrap-around is natural modulo.
- FSM states: IDLE, ISSUE, WAIT_RESP.
  - IDLE → ISSUE when the FIFO is non-empty.
  - ISSUE lasts exactly one cycle and pops the head entry.
    - `readOut` = !write and `writeOut` = write.
    - `destinationAddressOut` = address.
    - `requesterAddressOut` = `localRouterAddress`.
    - `dataOut` = data for writes, 0 for reads.
  - ISSUE → IDLE for writes (writes are posted; no reply). ISSUE → WAIT_RESP for reads, with the timer cleared.
  - WAIT_RESP: the timer increments each cycle.
    - A reply is a cycle with `readIn`=1, `writeIn`=0 and `requesterAddressIn` == `localRouterAddress`. On a reply: capture `dataIn`, pulse `respValid` with `respError`=0, go to IDLE.
    - When the timer reaches TIMEOUT_CYCLES-1 with no reply: pulse `respValid` with `respError`=1 and `respData`=0, go to IDLE.
    - If a reply arrives in that same terminal cycle, the reply wins.
- A reply-shaped flit seen in IDLE or ISSUE is ignored; late replies after a timeout are dropped.
- Pushes continue during ISSUE and WAIT_RESP. A push and a pop in the same cycle leave the count unchanged.
- `reset` asserted at any time, including mid-WAIT_RESP:
  - FIFO is emptied.
  - State goes to IDLE.
  - Timer is cleared.
  - All outputs go to 0, except `reqReady`, which is 1 after reset.

## Timing
- All outputs are registered.
- Reset values: `reqReady`=1; `respValid`, `respData`, `respError`, `busy` = 0; all flit outputs = 0.
- Push at cycle N into an empty FIFO with the FSM in IDLE:
  - `busy` = 1 from N+1.
  - Flit is visible during N+2 only; flit outputs return to 0 in N+3.
- Back-to-back writes issue every 2 cycles (IDLE, ISSUE).
- A reply accepted in cycle M gives `respValid` in M+1. The next flit can appear at M+3 at the earliest.
- A timeout pulse occurs TIMEOUT_CYCLES+1 cycles after the read flit cycle.
- `reqReady` deasserts in the cycle after the push that fills the FIFO, and reasserts in the cycle after a pop.

## Test plan
- Reset release, then push write {addr 0x0_05, data 0xA5} at N → `writeOut`=1 during N+2 only, `dataOut`=0xA5, `requesterAddressOut`=`localRouterAddress`; no `respValid`.
- Read of addr 0x1_03; bench returns a reply with data 0x3C 10 cycles after the flit → `respValid`=1, `respData`=0x3C, `respError`=0 one cycle later.
- Read with no reply → `respValid` with `respError`=1 and `respData`=0 exactly TIMEOUT_CYCLES+1 cycles after the flit; a reply injected afterwards produces no pulse.
- Push 5 requests with the FSM in WAIT_RESP → `reqReady` drops after the 4th push, the 5th is held off, and order is preserved on the flit port.
- Reply whose `requesterAddressIn` differs from `localRouterAddress` → ignored; timeout still fires.
- Assert `reset` in WAIT_RESP with 2 entries queued → next cycle all outputs are at reset values, no flits follow, and `busy`=0.
